// File: rtl/sm_run_ctrl.sv
// Run/step/halt sequencer for the CPU clock domain. It turns prescaler ticks into
// single-cycle cpuEn pulses, stops on a PC breakpoint, and counts the pulses it issues.
//
// state | meaning
// ------+------------------------------------------------------------
// HALT  | idle, no pulses; waits for a run or step request
// RUN   | one pulse per tick until halt request or breakpoint match
// STEP  | one pulse on the next tick, then back to HALT
module sm_run_ctrl #(
    parameter int DIV_SHIFT = 16,
    parameter bit BYPASS    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  divide,
    input  logic        runReq,
    input  logic        haltReq,
    input  logic        stepReq,
    input  logic        bpEnable,
    input  logic [31:0] bpAddr,
    input  logic [31:0] pc,
    output logic        cpuEn,
    output logic        running,
    output logic        halted,
    output logic        breakHit,
    output logic [31:0] cycleCount
);

    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    localparam logic [5:0] SHIFT_SAT = (DIV_SHIFT > 31) ? 6'd31 : 6'(DIV_SHIFT);

    state_t      state, stateNext;
    logic [31:0] cntr;
    logic [31:0] limit;
    logic [5:0]  nSum;
    logic [4:0]  nSat;
    logic        tick;
    logic        runReqD, haltReqD, stepReqD;
    logic        runEdge, haltEdge, stepEdge;
    logic        skipBp, skipBpNext;
    logic        breakHitNext;
    logic        pulse;
    logic        bpMatch;

    // Compare against the live limit so a shrinking divide takes effect at once.
    assign nSum  = SHIFT_SAT + {2'b00, divide};
    assign nSat  = (nSum > 6'd31) ? 5'd31 : nSum[4:0];
    assign limit = (32'd1 << nSat) - 32'd1;
    assign tick  = BYPASS ? 1'b1 : (cntr >= limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cntr <= '0;
        end else if (tick) begin
            cntr <= '0;
        end else begin
            cntr <= cntr + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            runReqD  <= 1'b0;
            haltReqD <= 1'b0;
            stepReqD <= 1'b0;
        end else begin
            runReqD  <= runReq;
            haltReqD <= haltReq;
            stepReqD <= stepReq;
        end
    end

    assign runEdge  = runReq & ~runReqD;
    assign haltEdge = haltReq & ~haltReqD;
    assign stepEdge = stepReq & ~stepReqD;
    assign bpMatch  = bpEnable & (pc == bpAddr) & ~skipBp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HALT;
            skipBp     <= 1'b0;
            breakHit   <= 1'b0;
            cpuEn      <= 1'b0;
            cycleCount <= '0;
        end else begin
            state      <= stateNext;
            skipBp     <= skipBpNext;
            breakHit   <= breakHitNext;
            cpuEn      <= pulse;
            cycleCount <= cycleCount + {31'd0, cpuEn};
        end
    end

    always_comb begin
        stateNext    = state;
        skipBpNext   = skipBp;
        breakHitNext = breakHit;
        pulse        = 1'b0;
        case (state)
            HALT: begin
                // A halt edge outranks run/step even though HALT is already idle.
                if (haltEdge) begin
                    stateNext = HALT;
                end else if (runEdge) begin
                    stateNext    = RUN;
                    skipBpNext   = 1'b1;
                    breakHitNext = 1'b0;
                end else if (stepEdge) begin
                    stateNext    = STEP;
                    breakHitNext = 1'b0;
                end
            end
            RUN: begin
                if (haltEdge) begin
                    stateNext = HALT;
                end else if (tick && bpMatch) begin
                    stateNext    = HALT;
                    breakHitNext = 1'b1;
                end else if (tick) begin
                    pulse      = 1'b1;
                    skipBpNext = 1'b0;
                end
            end
            STEP: begin
                if (haltEdge) begin
                    stateNext = HALT;
                end else if (tick) begin
                    pulse     = 1'b1;
                    stateNext = HALT;
                end
            end
            default: begin
                stateNext = HALT;
            end
        endcase
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl with DIV_SHIFT=2: a per-cycle vector table for
// run/halt, then hand-written sequences for step, breakpoint, divide change and reset.
module tb_sm_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  divide = 4'd0;
    logic        runReq = 1'b0;
    logic        haltReq = 1'b0;
    logic        stepReq = 1'b0;
    logic        bpEnable = 1'b0;
    logic [31:0] bpAddr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        cpuEn;
    logic        running;
    logic        halted;
    logic        breakHit;
    logic [31:0] cycleCount;

    int nChecks = 0;
    int nFail = 0;
    int cycleIdx = 0;

    typedef struct {
        logic        rst;
        logic        runReq;
        logic        haltReq;
        logic        stepReq;
        logic        expCpuEn;
        logic        expRunning;
        logic        expHalted;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs[47];

    sm_run_ctrl #(.DIV_SHIFT(2), .BYPASS(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .divide     (divide),
        .runReq     (runReq),
        .haltReq    (haltReq),
        .stepReq    (stepReq),
        .bpEnable   (bpEnable),
        .bpAddr     (bpAddr),
        .pc         (pc),
        .cpuEn      (cpuEn),
        .running    (running),
        .halted     (halted),
        .breakHit   (breakHit),
        .cycleCount (cycleCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkVec(logic r, logic ru, logic h, logic s,
                                   logic e, logic rn, logic hl, int cnt);
        vec_t v;
        v.rst        = r;
        v.runReq     = ru;
        v.haltReq    = h;
        v.stepReq    = s;
        v.expCpuEn   = e;
        v.expRunning = rn;
        v.expHalted  = hl;
        v.expCount   = 32'(cnt);
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        cycleIdx++;
    endtask

    task automatic doReset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cycleIdx = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleIdx);
        end
    endtask

    // Models the CPU: pc advances at the clock edge that consumes a cpuEn pulse.
    task automatic runCycle();
        logic en;
        en = cpuEn;
        cyc();
        if (en) pc = pc + 32'd4;
    endtask

    initial begin
        logic expEn;

        // Run from reset, period 4, then a halt edge that lands on a tick cycle.
        vecs[0] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int c = 0; c <= 42; c++) begin
            vecs[c + 1] = mkVec(1'b0, 1'b1, 1'b0, 1'b0,
                                (c >= 4) && (c % 4 == 0), c >= 1, c == 0,
                                (c >= 1) ? (c - 1) / 4 : 0);
        end
        vecs[44] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        vecs[45] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10);
        vecs[46] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10);

        rst = 1'b1;
        cyc();
        for (int i = 0; i < 47; i++) begin
            rst     = vecs[i].rst;
            runReq  = vecs[i].runReq;
            haltReq = vecs[i].haltReq;
            stepReq = vecs[i].stepReq;
            chk($sformatf("vec%0d cpuEn", i), 32'(cpuEn), 32'(vecs[i].expCpuEn));
            chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].expRunning));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].expHalted));
            chk($sformatf("vec%0d cycleCount", i), cycleCount, vecs[i].expCount);
            cyc();
        end
        runReq  = 1'b0;
        haltReq = 1'b0;

        // Three single steps, ticks on cycles 3,7,11,...
        doReset();
        cyc();
        for (int c = 1; c <= 35; c++) begin
            stepReq = (c == 1) || (c == 13) || (c == 25);
            expEn   = (c == 4) || (c == 16) || (c == 28);
            chk("step cpuEn", 32'(cpuEn), 32'(expEn));
            if (c == 2 || c == 14 || c == 26) begin
                chk("step inStep halted", 32'(halted), 0);
                chk("step inStep running", 32'(running), 0);
            end
            if (expEn) chk("step back halted", 32'(halted), 1);
            cyc();
        end
        stepReq = 1'b0;
        chk("step cycleCount", cycleCount, 3);

        // Breakpoint at 0x10, then resume past it.
        doReset();
        bpEnable = 1'b1;
        bpAddr   = 32'h10;
        pc       = 32'h0;
        runReq   = 1'b1;
        while (cycleIdx < 20) runCycle();
        chk("bp halted", 32'(halted), 1);
        chk("bp breakHit", 32'(breakHit), 1);
        chk("bp pc", pc, 32'h10);
        chk("bp cycleCount", cycleCount, 4);
        runReq = 1'b0;
        runCycle();
        runReq = 1'b1;
        runCycle();
        chk("bp resume breakHit", 32'(breakHit), 0);
        chk("bp resume running", 32'(running), 1);
        while (cycleIdx < 41) runCycle();
        chk("bp continue running", 32'(running), 1);
        chk("bp continue cycleCount", cycleCount, 9);
        chk("bp continue pc", pc, 32'h24);
        bpEnable = 1'b0;
        runReq   = 1'b0;

        // Simultaneous run and step edges in HALT.
        doReset();
        cyc();
        runReq  = 1'b1;
        stepReq = 1'b1;
        cyc();
        chk("runstep running", 32'(running), 1);
        chk("runstep halted", 32'(halted), 0);
        runReq  = 1'b0;
        stepReq = 1'b0;

        // cycleCount wrap.
        doReset();
        cyc();
        force dut.cycleCount = 32'hFFFF_FFFF;
        #1;
        release dut.cycleCount;
        stepReq = 1'b1;
        cyc();
        stepReq = 1'b0;
        cyc();
        cyc();
        chk("wrap cpuEn", 32'(cpuEn), 1);
        chk("wrap before", cycleCount, 32'hFFFF_FFFF);
        cyc();
        chk("wrap after", cycleCount, 0);
        chk("wrap halted", 32'(halted), 1);

        // runReq held through reset, divide 3->0 at cntr=20, then reset during RUN.
        divide = 4'd3;
        runReq = 1'b1;
        doReset();
        for (int c = 0; c <= 33; c++) begin
            if (c == 20) divide = 4'd0;
            if (c == 32) rst = 1'b1;
            expEn = (c == 21) || (c == 25) || (c == 29);
            chk($sformatf("div c%0d cpuEn", c), 32'(cpuEn), 32'(expEn));
            if (c == 0) chk("div c0 halted", 32'(halted), 1);
            if (c == 1) chk("div c1 running", 32'(running), 1);
            if (c == 33) chk("rst halted", 32'(halted), 1);
            cyc();
        end
        rst    = 1'b0;
        runReq = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
